i2s_master_tx: RTL and testbench

I2S_MASTER_TX -- requirements
Module: i2s_master_tx

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_clk_gen.sv | 47 ++++
 rtl/i2s_master_tx.sv | 99 +++++++++
 tb/tb_i2s_master_tx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: serial format encodings and slot legality check,
// used by both the transmit and receive sides.
package i2s_pkg;

  typedef enum logic {
    I2S_FMT_LJ      = 1'b0,
    I2S_FMT_PHILIPS = 1'b1
  } i2s_fmt_e;

  localparam int I2S_FORMAT_LJ      = 0;
  localparam int I2S_FORMAT_PHILIPS = 1;

  // A slot must hold the optional one-bit delay plus the whole sample.
  function automatic bit slot_fits(input int data_w, input int slot_w, input int fmt);
    return (slot_w >= data_w + fmt);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// SCLK divider and frame bit counter; emits the falling-event strobe and the
// word-select edge strobes that the serializer acts on.
module i2s_clk_gen #(
  parameter int SLOT_WIDTH = 32,
  parameter int SCLK_HALF  = 4,
  localparam int CNT_W = $clog2(2*SLOT_WIDTH),
  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic o_sclk,
  output logic o_fall,
  output logic o_load,
  output logic o_slot1
);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_sclk;
  logic             w_div_end;
  logic [CNT_W-1:0] w_bit_nxt;

  assign w_div_end = (r_div == DIV_W'(SCLK_HALF-1));
  assign o_fall    = w_div_end && r_sclk;
  assign w_bit_nxt = (r_bit_cnt == CNT_W'(2*SLOT_WIDTH-1)) ? '0 : r_bit_cnt + 1'b1;
  assign o_load    = o_fall && (w_bit_nxt == '0);
  assign o_slot1   = o_fall && (w_bit_nxt == CNT_W'(SLOT_WIDTH));
  assign o_sclk    = r_sclk;

  // bit_cnt resets to the last position so the first fall wraps it to 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_div     <= '0;
      r_sclk    <= 1'b0;
      r_bit_cnt <= CNT_W'(2*SLOT_WIDTH-1);
    end else begin
      if (w_div_end) begin
        r_div  <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_div  <= r_div + 1'b1;
      end
      if (o_fall) r_bit_cnt <= w_bit_nxt;
    end
  end

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: one-deep pending pair, frame-wide shift register
// loaded at each word-select fall, data/LRCLK changed on SCLK falling events.
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int SCLK_HALF  = 4,
  parameter int I2S_FORMAT = I2S_FORMAT_PHILIPS
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] left_data_i,
  input  logic [DATA_WIDTH-1:0] right_data_i,
  input  logic                  data_val_i,
  output logic                  data_ready_o,
  output logic                  i2s_sclk_o,
  output logic                  i2s_lrclk_o,
  output logic                  i2s_data_o,
  output logic                  frame_start_o,
  output logic                  underrun_o
);

  localparam int FRAME_W = 2*SLOT_WIDTH;
  localparam int PAD     = SLOT_WIDTH - DATA_WIDTH - I2S_FORMAT;

  if (!slot_fits(DATA_WIDTH, SLOT_WIDTH, I2S_FORMAT)) begin : g_bad_slot
    $error("i2s_master_tx: SLOT_WIDTH too small for DATA_WIDTH and format");
  end

  logic                  w_fall, w_load, w_slot1, w_hs;
  logic [SLOT_WIDTH-1:0] w_slot_l, w_slot_r;
  logic [FRAME_W-1:0]    w_frame;
  logic [FRAME_W-1:0]    r_shift;
  logic [DATA_WIDTH-1:0] r_pend_l, r_pend_r;
  logic                  r_pend_vld, r_lrclk, r_data, r_fs, r_ur;

  i2s_clk_gen #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .SCLK_HALF  (SCLK_HALF)
  ) u_clk_gen (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .o_sclk  (i2s_sclk_o),
    .o_fall  (w_fall),
    .o_load  (w_load),
    .o_slot1 (w_slot1)
  );

  assign w_hs     = data_val_i && !r_pend_vld;
  assign w_slot_l = SLOT_WIDTH'(r_pend_l) << PAD;
  assign w_slot_r = SLOT_WIDTH'(r_pend_r) << PAD;
  // An empty pending register at load time sends silence.
  assign w_frame  = r_pend_vld ? {w_slot_l, w_slot_r} : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_shift <= '0;
      r_data  <= 1'b0;
      r_lrclk <= 1'b1;
      r_fs    <= 1'b0;
      r_ur    <= 1'b0;
    end else begin
      r_fs <= w_load;
      r_ur <= w_load && !r_pend_vld;
      if (w_load) begin
        r_data  <= w_frame[FRAME_W-1];
        r_shift <= w_frame << 1;
        r_lrclk <= 1'b0;
      end else if (w_fall) begin
        r_data  <= r_shift[FRAME_W-1];
        r_shift <= r_shift << 1;
        if (w_slot1) r_lrclk <= 1'b1;
      end
    end
  end

  // A handshake in the load cycle (pending empty) is kept for the next frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pend_vld <= 1'b0;
      r_pend_l   <= '0;
      r_pend_r   <= '0;
    end else if (w_load && r_pend_vld) begin
      r_pend_vld <= 1'b0;
    end else if (w_hs) begin
      r_pend_vld <= 1'b1;
      r_pend_l   <= left_data_i;
      r_pend_r   <= right_data_i;
    end
  end

  assign data_ready_o  = !r_pend_vld;
  assign i2s_lrclk_o   = r_lrclk;
  assign i2s_data_o    = r_data;
  assign frame_start_o = r_fs;
  assign underrun_o    = r_ur;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Randomized bench for i2s_master_tx: Philips and left-justified instances share
// stimulus; a frame-level model predicts every output bit each cycle.
module tb_i2s_master_tx;

  localparam int DW  = 24;
  localparam int SW  = 32;
  localparam int SH  = 2;
  localparam int PER = 2*SH;
  localparam int FR  = 2*SW*PER;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          val = 1'b0;
  logic [DW-1:0] ldat = '0, rdat = '0;
  logic [1:0]    rdy, sclk, lr, dat, fs, ur;

  int errs = 0, checks = 0;
  int t = 0;
  bit mpend = 0;
  logic [DW-1:0] mpl = '0, mpr = '0, mfl = '0, mfr = '0;
  bit e_fs = 0, e_ur = 0;

  always #5 clk = ~clk;

  i2s_master_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .SCLK_HALF(SH), .I2S_FORMAT(1)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .left_data_i(ldat), .right_data_i(rdat),
    .data_val_i(val), .data_ready_o(rdy[0]), .i2s_sclk_o(sclk[0]), .i2s_lrclk_o(lr[0]),
    .i2s_data_o(dat[0]), .frame_start_o(fs[0]), .underrun_o(ur[0]));

  i2s_master_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .SCLK_HALF(SH), .I2S_FORMAT(0)) u_dut_lj (
    .clk_i(clk), .rst_n_i(rst_n), .left_data_i(ldat), .right_data_i(rdat),
    .data_val_i(val), .data_ready_o(rdy[1]), .i2s_sclk_o(sclk[1]), .i2s_lrclk_o(lr[1]),
    .i2s_data_o(dat[1]), .frame_start_o(fs[1]), .underrun_o(ur[1]));

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%b exp=%b t=%0d time=%0t", tag, got, exp, t, $time);
    end
  endtask

  // Bit j of the 2*SW-bit frame as the codec should see it.
  function automatic logic exp_bit(input logic [DW-1:0] sl, input logic [DW-1:0] sr,
                                   input int j, input int fmt);
    int k;
    logic [DW-1:0] s;
    k = j % SW;
    s = (j >= SW) ? sr : sl;
    if (k >= fmt && k < fmt + DW) return s[DW-1-(k-fmt)];
    return 1'b0;
  endfunction

  task automatic check_outputs();
    int  j;
    logic e_sclk, e_lr, e_dat;
    j = (t >= PER) ? ((t - PER) / PER) % (2*SW) : 0;
    e_sclk = (t > 0) && (((t / SH) % 2) == 1);
    e_lr   = (t < PER) ? 1'b1 : (j >= SW);
    for (int d = 0; d < 2; d++) begin
      e_dat = (t < PER) ? 1'b0 : exp_bit(mfl, mfr, j, (d == 0) ? 1 : 0);
      chk($sformatf("sclk%0d", d),  sclk[d], e_sclk);
      chk($sformatf("lrclk%0d", d), lr[d],   e_lr);
      chk($sformatf("data%0d", d),  dat[d],  e_dat);
      chk($sformatf("ready%0d", d), rdy[d],  !mpend);
      chk($sformatf("fstart%0d", d), fs[d],  e_fs);
      chk($sformatf("underrun%0d", d), ur[d], e_ur);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check after it.
  task automatic cyc(input bit v, input logic [DW-1:0] dl, input logic [DW-1:0] dr);
    bit ld, hs;
    val = v; ldat = dl; rdat = dr;
    @(posedge clk);
    if (!rst_n) begin
      t = 0; mpend = 0; mfl = '0; mfr = '0; e_fs = 0; e_ur = 0;
    end else begin
      t++;
      ld = (t >= PER) && ((t - PER) % FR == 0);
      hs = v && !mpend;
      e_fs = ld;
      e_ur = ld && !mpend;
      if (ld) begin
        if (mpend) begin mfl = mpl; mfr = mpr; mpend = 0; end
        else begin mfl = '0; mfr = '0; end
      end
      if (hs) begin mpend = 1; mpl = dl; mpr = dr; end
    end
    #1;
    check_outputs();
  endtask

  task automatic cyc_rand(input bit v);
    cyc(v, DW'($urandom), DW'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout errors=%0d checks=%0d", errs, checks);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) cyc(0, '0, '0);
    @(negedge clk) rst_n = 1'b1;

    // No data: first frame silent with one underrun; then a handshake that
    // lands exactly on the second load.
    while (t < PER + FR - 1) cyc(0, '0, '0);
    cyc(1, 24'h800001, 24'h7FFFFE);
    while (t < PER + 2*FR + 20) cyc(0, '0, '0);
    for (int n = 0; n < 8 && !mpend; n++) cyc(1, 24'hA5A5A5, 24'h5A5A5A);
    while (t < PER + 4*FR) cyc(0, '0, '0);

    // Valid held high with changing data, then sparse random valid.
    repeat (3*FR) cyc_rand(1);
    repeat (3*FR) cyc_rand($urandom_range(0, 3) == 0);

    // Reset while bit_cnt sits at 40 with a pair pending.
    for (int n = 0; n < FR && ((t - PER) % FR) != 40*PER; n++) cyc_rand(1);
    repeat (2) cyc_rand(1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_sclk%0d", d),  sclk[d], 1'b0);
      chk($sformatf("rst_lrclk%0d", d), lr[d],   1'b1);
      chk($sformatf("rst_data%0d", d),  dat[d],  1'b0);
      chk($sformatf("rst_ready%0d", d), rdy[d],  1'b1);
      chk($sformatf("rst_fs%0d", d),    fs[d],   1'b0);
      chk($sformatf("rst_ur%0d", d),    ur[d],   1'b0);
    end
    repeat (3) cyc(0, '0, '0);
    @(negedge clk) rst_n = 1'b1;
    while (t < PER + 2) cyc(0, '0, '0);
    repeat (2*FR) cyc_rand($urandom_range(0, 1) == 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
